nv_fifo_rws_256x27_ctrl: RTL and testbench

Flow-controlled 256-entry × 27-bit FIFO built around one `nv_ram_rws_256x27` 1R1W RAM instance. It sequences RAM writes and reads from valid/ready handshakes. It manages pointers and occupancy, and uses the RAM's held read address as the output holding register. It sits between a producer and a consumer in the core clock domain wherever a 27-bit stream needs deep buffering.

---
 rtl/nv_fifo_rws_256x27_ctrl_pkg.sv | 35 +++
 rtl/nv_fifo_rws_256x27_ctrl_ram.sv | 46 ++++
 rtl/nv_fifo_rws_256x27_ctrl.sv | 101 ++++++++++
 tb/tb_nv_fifo_rws_256x27_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nv_fifo_rws_256x27_ctrl_pkg.sv
// Shared sizing constants and occupancy classification for the 256x27 RAM-backed FIFO.
`default_nettype none

package nv_fifo_rws_256x27_ctrl_pkg;

   localparam int DEPTH = 256;
   localparam int WIDTH = 27;
   localparam int AW    = 8;
   localparam int CW    = 9;

   localparam logic [CW-1:0] FULL_COUNT = 9'd256;

   typedef logic [CW-1:0]    ptr_t;
   typedef logic [AW-1:0]    addr_t;
   typedef logic [WIDTH-1:0] data_t;

   typedef enum logic [1:0] {
      FIFO_EMPTY  = 2'd0,
      FIFO_ACTIVE = 2'd1,
      FIFO_FULL   = 2'd2
   } fifo_state_e;

   function automatic fifo_state_e fifo_state(input ptr_t count);
      if (count == '0) begin
         return FIFO_EMPTY;
      end else if (count == FULL_COUNT) begin
         return FIFO_FULL;
      end else begin
         return FIFO_ACTIVE;
      end
   endfunction

endpackage

`default_nettype wire

// File: rtl/nv_fifo_rws_256x27_ctrl_ram.sv
// 256x27 1R1W RAM with a registered read address; dout follows the held address.
`default_nettype none

module nv_ram_rws_256x27
   import nv_fifo_rws_256x27_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic [AW-1:0]    ra,
   input  logic             re,
   output logic [WIDTH-1:0] dout,
   input  logic [AW-1:0]    wa,
   input  logic             we,
   input  logic [WIDTH-1:0] di,
   input  logic [31:0]      pwrbus_ram_pd
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    ra_d;
   logic [AW-1:0]    ra_q;
   logic             unused_pwrbus;

   // Power-control bus has no behavioural effect in this model.
   assign unused_pwrbus = ^pwrbus_ram_pd;

   always_comb begin
      ra_d = ra_q;
      if (re) begin
         ra_d = ra;
      end
   end

   always_ff @(posedge clk) begin
      ra_q <= ra_d;
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= di;
      end
   end

   assign dout = mem[ra_q];

endmodule

`default_nettype wire

// File: rtl/nv_fifo_rws_256x27_ctrl.sv
// Valid/ready FIFO controller around one 256x27 RAM; the RAM's held read address
// doubles as the output holding register.
`default_nettype none

module nv_fifo_rws_256x27_ctrl
   import nv_fifo_rws_256x27_ctrl_pkg::*;
(
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             wr_pvld,
   output logic             wr_prdy,
   input  logic [WIDTH-1:0] wr_pd,
   output logic             rd_pvld,
   input  logic             rd_prdy,
   output logic [WIDTH-1:0] rd_pd,
   output logic [CW-1:0]    fifo_count,
   output logic             idle,
   input  logic [31:0]      pwrbus_ram_pd
);

   ptr_t  wr_ptr_q, wr_ptr_d;
   ptr_t  re_ptr_q, re_ptr_d;
   ptr_t  count_q,  count_d;
   logic  rd_pvld_q, rd_pvld_d;
   logic  wr_prdy_q, wr_prdy_d;

   logic  push;
   logic  pop;
   logic  rd_issue;
   ptr_t  unread;

   assign push   = wr_pvld & wr_prdy_q;
   assign pop    = rd_pvld_q & rd_prdy;
   // Committed pointers only: a word written this cycle becomes readable next cycle.
   assign unread = wr_ptr_q - re_ptr_q;
   assign rd_issue = (unread != '0) & (~rd_pvld_q | rd_prdy);

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      re_ptr_d  = re_ptr_q;
      count_d   = count_q;
      rd_pvld_d = rd_pvld_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + 9'd1;
      end
      if (rd_issue) begin
         re_ptr_d = re_ptr_q + 9'd1;
      end

      if (rd_issue) begin
         rd_pvld_d = 1'b1;
      end else if (pop) begin
         rd_pvld_d = 1'b0;
      end

      // The presented word stays counted until popped, protecting its RAM slot.
      if (push && !pop) begin
         count_d = count_q + 9'd1;
      end else if (pop && !push) begin
         count_d = count_q - 9'd1;
      end

      wr_prdy_d = (count_d != FULL_COUNT);
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         wr_ptr_q  <= '0;
         re_ptr_q  <= '0;
         count_q   <= '0;
         rd_pvld_q <= 1'b0;
         wr_prdy_q <= 1'b1;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         re_ptr_q  <= re_ptr_d;
         count_q   <= count_d;
         rd_pvld_q <= rd_pvld_d;
         wr_prdy_q <= wr_prdy_d;
      end
   end

   nv_ram_rws_256x27 u_ram (
      .clk           (nvdla_core_clk),
      .ra            (re_ptr_q[AW-1:0]),
      .re            (rd_issue),
      .dout          (rd_pd),
      .wa            (wr_ptr_q[AW-1:0]),
      .we            (push),
      .di            (wr_pd),
      .pwrbus_ram_pd (pwrbus_ram_pd)
   );

   assign wr_prdy    = wr_prdy_q;
   assign rd_pvld    = rd_pvld_q;
   assign fifo_count = count_q;
   assign idle       = (fifo_state(count_q) == FIFO_EMPTY);

endmodule

`default_nettype wire

// File: tb/tb_nv_fifo_rws_256x27_ctrl.sv
// Directed bench for the 256x27 FIFO: queue-based reference model checked every
// cycle, plus hand-computed literal checkpoints.
`default_nettype none

module tb_nv_fifo_rws_256x27_ctrl;

   logic        clk;
   logic        rstn;
   logic        wr_pvld;
   logic        wr_prdy;
   logic [26:0] wr_pd;
   logic        rd_pvld;
   logic        rd_prdy;
   logic [26:0] rd_pd;
   logic [8:0]  fifo_count;
   logic        idle;
   logic [31:0] pwrbus;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: queue of all stored words plus a "head is presented" flag.
   logic [26:0] mq[$];
   bit          m_pres = 0;
   int          rx_cnt = 0;
   int          max_cnt = 0;

   nv_fifo_rws_256x27_ctrl dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .wr_pvld         (wr_pvld),
      .wr_prdy         (wr_prdy),
      .wr_pd           (wr_pd),
      .rd_pvld         (rd_pvld),
      .rd_prdy         (rd_prdy),
      .rd_pd           (rd_pd),
      .fifo_count      (fifo_count),
      .idle            (idle),
      .pwrbus_ram_pd   (pwrbus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update on each edge: pop the head if presented and accepted, push if
   // not full; a word pushed before this edge can be presented after it.
   initial begin
      bit m_pop, m_push;
      int avail;
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) begin
            mq.delete();
            m_pres = 0;
         end else begin
            m_pop  = m_pres && rd_prdy;
            m_push = wr_pvld && (mq.size() != 256);
            if (m_pop) begin
               void'(mq.pop_front());
               rx_cnt++;
            end
            avail = mq.size();
            if (m_push) mq.push_back(wr_pd);
            m_pres = (m_pres && !m_pop) || (avail > 0);
         end
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("count", {23'd0, fifo_count}, mq.size());
         chk("idle", {31'd0, idle}, {31'd0, mq.size() == 0});
         chk("wr_prdy", {31'd0, wr_prdy}, {31'd0, mq.size() != 256});
         chk("rd_pvld", {31'd0, rd_pvld}, {31'd0, m_pres});
         if (m_pres && mq.size() > 0) chk("rd_pd", {5'd0, rd_pd}, {5'd0, mq[0]});
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      end
   end

   task automatic step(input bit v, input logic [26:0] d, input bit r);
      wr_pvld = v;
      wr_pd   = d;
      rd_prdy = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      wr_pvld = 0;
      wr_pd   = '0;
      rd_prdy = 0;
      pwrbus  = 32'h0;
      rstn    = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1;
      @(posedge clk);
      #1;

      // Reset state
      chk("rst_wr_prdy", {31'd0, wr_prdy}, 32'd1);
      chk("rst_rd_pvld", {31'd0, rd_pvld}, 32'd0);
      chk("rst_count", {23'd0, fifo_count}, 32'd0);
      chk("rst_idle", {31'd0, idle}, 32'd1);

      // Single entry: count 0,1,1,0 over cycles 0..3
      step(1, 27'h5A5A5A, 1);
      wr_pvld = 0;
      @(negedge clk);
      chk("single_c1_count", {23'd0, fifo_count}, 32'd1);
      chk("single_c1_pvld", {31'd0, rd_pvld}, 32'd0);
      @(negedge clk);
      chk("single_c2_count", {23'd0, fifo_count}, 32'd1);
      chk("single_c2_pvld", {31'd0, rd_pvld}, 32'd1);
      chk("single_c2_pd", {5'd0, rd_pd}, 32'h5A5A5A);
      @(negedge clk);
      chk("single_c3_count", {23'd0, fifo_count}, 32'd0);
      chk("single_c3_idle", {31'd0, idle}, 32'd1);
      chk("single_c3_pvld", {31'd0, rd_pvld}, 32'd0);
      @(posedge clk);
      #1;

      // Fill with 0..255, then offer a 257th word
      for (int i = 0; i < 256; i++) step(1, 27'(i), 0);
      @(negedge clk);
      chk("fill_wr_prdy", {31'd0, wr_prdy}, 32'd0);
      chk("fill_count", {23'd0, fifo_count}, 32'd256);
      @(posedge clk);
      #1;
      step(1, 27'h7FFFFFF, 0);
      step(0, 27'h0, 0);
      @(negedge clk);
      chk("fill_257_count", {23'd0, fifo_count}, 32'd256);
      chk("fill_head_pd", {5'd0, rd_pd}, 32'd0);
      @(posedge clk);
      #1;

      // Drain in order
      step(0, 27'h0, 1);
      @(negedge clk);
      chk("drain_wr_prdy_rise", {31'd0, wr_prdy}, 32'd1);
      chk("drain_count_255", {23'd0, fifo_count}, 32'd255);
      @(posedge clk);
      #1;
      for (int i = 1; i < 256; i++) step(0, 27'h0, 1);
      @(negedge clk);
      chk("drain_empty_count", {23'd0, fifo_count}, 32'd0);
      chk("drain_pvld_low", {31'd0, rd_pvld}, 32'd0);
      chk("drain_rx_total", rx_cnt, 32'd257);
      @(posedge clk);
      #1;

      // Wrap-around streaming of 600 words
      max_cnt = 0;
      rx_cnt  = 0;
      for (int i = 0; i < 600; i++) step(1, 27'(1000 + i), 1);
      for (int i = 0; i < 4; i++) step(0, 27'h0, 1);
      @(negedge clk);
      chk("wrap_rx_total", rx_cnt, 32'd600);
      chk("wrap_max_count_le2", {31'd0, max_cnt <= 2}, 32'd1);
      @(posedge clk);
      #1;

      // Random backpressure
      for (int i = 0; i < 500; i++)
         step(1'($urandom_range(0, 1)), 27'($urandom), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 300; i++) step(0, 27'h0, 1);
      @(negedge clk);
      chk("bp_drained", {23'd0, fifo_count}, 32'd0);
      @(posedge clk);
      #1;

      // Async reset mid-burst at count 100
      for (int i = 0; i < 100; i++) step(1, 27'(i + 27'h100), 0);
      wr_pvld = 0;
      @(negedge clk);
      chk("arst_pre_count", {23'd0, fifo_count}, 32'd100);
      #2;
      rstn = 0;
      #1;
      chk("arst_pvld", {31'd0, rd_pvld}, 32'd0);
      chk("arst_count", {23'd0, fifo_count}, 32'd0);
      chk("arst_wr_prdy", {31'd0, wr_prdy}, 32'd1);
      chk("arst_idle", {31'd0, idle}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      rstn = 1;
      @(posedge clk);
      #1;
      step(1, 27'h1234567, 0);
      wr_pvld = 0;
      @(negedge clk);
      @(negedge clk);
      chk("arst_new_pvld", {31'd0, rd_pvld}, 32'd1);
      chk("arst_new_pd", {5'd0, rd_pd}, 32'h1234567);
      @(posedge clk);
      #1;
      step(0, 27'h0, 1);
      step(0, 27'h0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
